// File: rtl/icache_pkg.sv
// Shared types and address-decode helpers for the dual-lane instruction cache.
// Default geometry: 32-bit PCs, 4-word lines, 64 lines.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  localparam int ADDR_W_DEF     = 32;
  localparam int INSTR_W_DEF    = 32;
  localparam int LINE_WORDS_DEF = 4;
  localparam int NUM_LINES_DEF  = 64;

  localparam int WORD_W = $clog2(LINE_WORDS_DEF);
  localparam int OFF_W  = 2 + WORD_W;
  localparam int IDX_W  = $clog2(NUM_LINES_DEF);
  localparam int TAG_W  = ADDR_W_DEF - OFF_W - IDX_W;

  // Helpers take the PC zero-extended to 64 bits plus the field
  // geometry; callers size-cast the result to the field width.
  function automatic logic [63:0] pc_word(
    input logic [63:0] pc,
    input int          word_w
  );
    return (pc >> 2) & ((64'd1 << word_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_idx(
    input logic [63:0] pc,
    input int          off_w,
    input int          idx_w
  );
    return (pc >> off_w) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(
    input logic [63:0] pc,
    input int          off_w,
    input int          idx_w
  );
    return pc >> (off_w + idx_w);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Line-refill engine: IDLE -> REQ -> FILL FSM, beat counter, discard flag.
// Ports: start/start_addr open a refill, flush marks an in-flight refill
// as discarded; mem_req_* is the request handshake, mem_resp_valid counts
// beats; beat_we/beat_word steer data writes, fill_done writes the tag,
// fill_commit sets the line valid; line_addr is the latched line address.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter  int ADDR_WIDTH = ADDR_W_DEF,
  parameter  int LINE_WORDS = LINE_WORDS_DEF,
  localparam int WORD_BITS  = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  flush,
  output logic                  idle,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  output logic [ADDR_WIDTH-1:0] line_addr,
  output logic                  beat_we,
  output logic [WORD_BITS-1:0]  beat_word,
  output logic                  fill_done,
  output logic                  fill_commit
);

  localparam logic [WORD_BITS-1:0] LAST =
    WORD_BITS'(LINE_WORDS - 1);

  state_e                  state_q, state_d;
  logic [WORD_BITS-1:0]    cnt_q, cnt_d;
  logic                    discard_q, discard_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    discard_d     = discard_q;
    addr_d        = addr_q;
    mem_req_valid = 1'b0;
    beat_we       = 1'b0;
    fill_done     = 1'b0;
    fill_commit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          addr_d    = start_addr;
          discard_d = 1'b0;
          cnt_d     = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (flush) discard_d = 1'b1;
        if (mem_req_ready) state_d = FILL;
      end
      FILL: begin
        if (flush) discard_d = 1'b1;
        if (mem_resp_valid) begin
          beat_we = 1'b1;
          if (cnt_q == LAST) begin
            fill_done = 1'b1;
            // A flush on the last beat must also keep the line invalid.
            fill_commit = !discard_q && !flush;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
    end
  end

  assign idle         = (state_q == IDLE);
  assign mem_req_addr = addr_q;
  assign line_addr    = addr_q;
  assign beat_word    = cnt_q;

endmodule

// File: rtl/icache_dual_fetch.sv
// Direct-mapped instruction cache with two same-cycle fetch lanes.
// Ports: reqF1/pcF1 and reqF2/pcF2 in, instrFN/validFN out, stallF holds
// fetch on any miss or refill, flush invalidates all lines; mem_req_*
// issues line refills and mem_resp_* delivers beats, word 0 first.
module icache_dual_fetch
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W_DEF,
  parameter int INSTR_WIDTH = INSTR_W_DEF,
  parameter int LINE_WORDS  = LINE_WORDS_DEF,
  parameter int NUM_LINES   = NUM_LINES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reqF1,
  input  logic                   reqF2,
  input  logic [ADDR_WIDTH-1:0]  pcF1,
  input  logic [ADDR_WIDTH-1:0]  pcF2,
  input  logic                   flush,
  output logic [INSTR_WIDTH-1:0] instrF1,
  output logic [INSTR_WIDTH-1:0] instrF2,
  output logic                   validF1,
  output logic                   validF2,
  output logic                   stallF,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_resp_data
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int OFF_BITS  = 2 + WORD_BITS;
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;

  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TAG_BITS-1:0]    tag_ram [NUM_LINES];
  logic [INSTR_WIDTH-1:0] data_ram [NUM_LINES][LINE_WORDS];

  logic [IDX_BITS-1:0]    idx1, idx2, miss_idx, fill_idx;
  logic [TAG_BITS-1:0]    tag1, tag2, fill_tag;
  logic [WORD_BITS-1:0]   word1, word2, beat_word;
  logic [ADDR_WIDTH-1:0]  line1, line2, miss_addr, line_addr;
  logic                   hit1, hit2, miss1, miss2;
  logic                   idle, start;
  logic                   beat_we, fill_done, fill_commit;

  assign idx1  = IDX_BITS'(pc_idx(64'(pcF1), OFF_BITS, IDX_BITS));
  assign idx2  = IDX_BITS'(pc_idx(64'(pcF2), OFF_BITS, IDX_BITS));
  assign tag1  = TAG_BITS'(pc_tag(64'(pcF1), OFF_BITS, IDX_BITS));
  assign tag2  = TAG_BITS'(pc_tag(64'(pcF2), OFF_BITS, IDX_BITS));
  assign word1 = WORD_BITS'(pc_word(64'(pcF1), WORD_BITS));
  assign word2 = WORD_BITS'(pc_word(64'(pcF2), WORD_BITS));

  assign line1 = {pcF1[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign line2 = {pcF2[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};

  assign hit1  = valid_q[idx1] && (tag_ram[idx1] == tag1);
  assign hit2  = valid_q[idx2] && (tag_ram[idx2] == tag2);
  assign miss1 = reqF1 && !hit1;
  assign miss2 = reqF2 && !hit2;

  // Lane 1 has priority; lane 2 re-misses after lane 1's refill.
  assign miss_addr = miss1 ? line1 : line2;
  assign miss_idx  = miss1 ? idx1 : idx2;
  assign start     = idle && (miss1 || miss2) && !flush;

  assign fill_idx =
    IDX_BITS'(pc_idx(64'(line_addr), OFF_BITS, IDX_BITS));
  assign fill_tag =
    TAG_BITS'(pc_tag(64'(line_addr), OFF_BITS, IDX_BITS));

  assign validF1 = reqF1 && hit1 && idle;
  assign validF2 = reqF2 && hit2 && idle;
  assign instrF1 = validF1 ? data_ram[idx1][word1] : '0;
  assign instrF2 = validF2 ? data_ram[idx2][word2] : '0;
  assign stallF  = !idle || miss1 || miss2;

  icache_refill_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_refill (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_addr     (miss_addr),
    .flush          (flush),
    .idle           (idle),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .line_addr      (line_addr),
    .beat_we        (beat_we),
    .beat_word      (beat_word),
    .fill_done      (fill_done),
    .fill_commit    (fill_commit)
  );

  // The refilling line is invalid while its data is partially written;
  // flush overrides everything, including a completing refill.
  always_comb begin
    valid_d = valid_q;
    if (start)       valid_d[miss_idx] = 1'b0;
    if (fill_commit) valid_d[fill_idx] = 1'b1;
    if (flush)       valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (beat_we)   data_ram[fill_idx][beat_word] <= mem_resp_data;
    if (fill_done) tag_ram[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_icache_dual_fetch.sv
// Scoreboard bench for icache_dual_fetch: random fetch pairs against
// a line-granular cache model and a randomised memory responder.
module tb_icache_dual_fetch;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqF1 = 1'b0, reqF2 = 1'b0;
  logic [31:0] pcF1 = '0, pcF2 = '0;
  logic        flush_drv = 1'b0, flush_mid = 1'b0;
  logic        flush;
  logic [31:0] instrF1, instrF2;
  logic        validF1, validF2, stallF;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  assign flush = flush_drv | flush_mid;

  always #5 clk = ~clk;

  icache_dual_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .reqF1          (reqF1),
    .reqF2          (reqF2),
    .pcF1           (pcF1),
    .pcF2           (pcF2),
    .flush          (flush),
    .instrF1        (instrF1),
    .instrF2        (instrF2),
    .validF1        (validF1),
    .validF2        (validF2),
    .stallF         (stallF),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  endtask

  // Backing memory contents, one word per aligned address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    logic [31:0] w;
    w = a - (a % 4);
    if (w >= 32'h100 && w < 32'h110) return 32'hA0 + (w - 32'h100) / 4;
    return (w * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // Reference model: which line address each cache slot holds.
  bit          m_valid [64];
  logic [31:0] m_line  [64];

  function automatic int m_slot(input logic [31:0] pc);
    return int'((pc / 16) % 64);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] pc);
    return pc - (pc % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_slot(pc)] && m_line[m_slot(pc)] == line_of(pc);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  typedef struct {
    bit          r1;
    logic [31:0] d1;
    bit          r2;
    logic [31:0] d2;
  } fexp_t;

  logic [31:0] req_q [$];
  fexp_t       fetch_q [$];

  bit fetch_active = 1'b0;
  int hold_tok = 0;
  int fm_tok = 0;

  // Monitor: one completed fetch group per unstalled cycle.
  always @(negedge clk) begin
    if (fetch_active && !rst && !stallF) begin
      if (fetch_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fetch_unexpected at %0t", $time);
      end else begin
        fexp_t e;
        e = fetch_q.pop_front();
        chk("validF1", 32'(validF1), 32'(e.r1));
        chk("instrF1", instrF1, e.d1);
        chk("validF2", 32'(validF2), 32'(e.r2));
        chk("instrF2", instrF2, e.d2);
      end
    end
  end

  // Memory responder: random ready delay, beat gaps, stray beats when idle.
  initial begin : responder
    bit          busy = 1'b0;
    int          beat = 0;
    logic [31:0] rline = '0;
    int          hold_left = 0;
    int          hold_seen = 0;
    int          fm_seen = 0;
    bit          s_hs, s_beat, prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] s_addr, prev_a = '0;
    forever begin
      @(negedge clk);
      s_hs   = !rst && mem_req_valid && mem_req_ready;
      s_beat = !rst && busy && mem_resp_valid;
      s_addr = mem_req_addr;
      if (!rst && prev_v && !prev_r) begin
        chk("req_valid_hold", 32'(mem_req_valid), 32'd1);
        chk("req_addr_hold", mem_req_addr, prev_a);
      end
      prev_v = !rst && mem_req_valid;
      prev_r = mem_req_ready;
      prev_a = mem_req_addr;
      @(posedge clk);
      #1;
      flush_mid = 1'b0;
      if (rst) begin
        busy = 1'b0;
        beat = 0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        continue;
      end
      if (s_beat) begin
        beat++;
        if (beat == LW) busy = 1'b0;
      end
      if (s_hs) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL req_unexpected: got %h", s_addr);
        end else begin
          chk("req_addr", s_addr, req_q.pop_front());
        end
        busy  = 1'b1;
        beat  = 0;
        rline = s_addr;
      end
      if (hold_seen != hold_tok) begin
        hold_seen = hold_tok;
        hold_left = 5;
      end
      if (hold_left > 0) begin
        mem_req_ready = 1'b0;
        if (mem_req_valid) hold_left--;
      end else begin
        mem_req_ready = ($urandom_range(0, 2) != 0);
      end
      if (fm_seen != fm_tok && busy && beat == 2) begin
        flush_mid = 1'b1;
        fm_seen   = fm_tok;
      end
      if (busy) begin
        mem_resp_valid = ($urandom_range(0, 3) != 0);
        mem_resp_data  = mem_resp_valid ?
                         mem_data(rline + 32'(4 * beat)) : $urandom;
      end else begin
        mem_resp_valid = ($urandom_range(0, 7) == 0);
        mem_resp_data  = $urandom;
      end
    end
  end

  // Predict the refill sequence, present the pair, hold until unstalled.
  task automatic run_group(input bit r1, input logic [31:0] p1,
                           input bit r2, input logic [31:0] p2,
                           input bit fm);
    int    nreq = 0;
    int    stalls = 0;
    fexp_t e;
    for (int it = 0; it < 4; it++) begin
      logic [31:0] mp;
      bit          m;
      m = 1'b0;
      mp = '0;
      if (r1 && !m_hit(p1)) begin
        m = 1'b1;
        mp = p1;
      end else if (r2 && !m_hit(p2)) begin
        m = 1'b1;
        mp = p2;
      end
      if (!m) break;
      req_q.push_back(line_of(mp));
      if (fm && nreq == 0) m_clear();
      else begin
        m_valid[m_slot(mp)] = 1'b1;
        m_line[m_slot(mp)]  = line_of(mp);
      end
      nreq++;
    end
    e.r1 = r1;
    e.d1 = r1 ? mem_data(p1) : 32'd0;
    e.r2 = r2;
    e.d2 = r2 ? mem_data(p2) : 32'd0;
    fetch_q.push_back(e);
    @(posedge clk);
    #1;
    reqF1 = r1;
    pcF1  = p1;
    reqF2 = r2;
    pcF2  = p2;
    fetch_active = 1'b1;
    if (fm && nreq > 0) fm_tok++;
    forever begin
      @(negedge clk);
      if (!stallF) break;
      stalls++;
      if (stalls > 400) begin
        n_cmp++;
        n_bad++;
        $display("FAIL group_timeout: pc %h/%h still stalled", p1, p2);
        summary_and_finish();
      end
    end
    if (nreq == 0) chk("stall_on_hit", 32'(stalls), 32'd0);
    else chk("miss_penalty", 32'(stalls >= 6 * nreq), 32'd1);
  endtask

  task automatic flush_idle();
    @(posedge clk);
    #1;
    fetch_active = 1'b0;
    reqF1 = 1'b0;
    reqF2 = 1'b0;
    flush_drv = 1'b1;
    @(posedge clk);
    #1;
    flush_drv = 1'b0;
    m_clear();
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 10) |
           (32'($urandom_range(0, 15)) << 4) |
           32'($urandom_range(0, 15));
  endfunction

  initial begin : watchdog
    #1_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit");
    summary_and_finish();
  end

  initial begin : main
    int n;
    m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 32'(stallF), 32'd0);
    chk("rst_req_valid_out", 32'(mem_req_valid), 32'd0);
    chk("rst_validF1", 32'(validF1), 32'd0);
    chk("rst_instrF1", instrF1, 32'd0);
    reqF1 = 1'b1;
    pcF1  = 32'h100;
    #1;
    chk("cold_miss_stall", 32'(stallF), 32'd1);
    chk("cold_validF1", 32'(validF1), 32'd0);
    reqF1 = 1'b0;

    run_group(1, 32'h100, 0, 32'h0, 0);
    run_group(1, 32'h10C, 0, 32'h0, 0);
    run_group(1, 32'h104, 1, 32'h108, 0);
    run_group(1, 32'h200, 1, 32'h210, 0);
    hold_tok++;
    run_group(1, 32'h400, 0, 32'h0, 0);
    run_group(1, 32'h504, 0, 32'h0, 1);
    run_group(1, 32'h508, 1, 32'h50C, 0);
    flush_idle();
    run_group(1, 32'h100, 0, 32'h0, 0);
    run_group(0, 32'h0, 1, 32'h3F0, 0);

    n = 0;
    while (n < 150) begin
      bit          r1, r2, fm;
      logic [31:0] p1, p2;
      r1 = ($urandom_range(0, 7) != 0);
      r2 = ($urandom_range(0, 7) != 0);
      p1 = rand_pc();
      p2 = ($urandom_range(0, 2) == 0) ?
           (line_of(p1) | 32'($urandom_range(0, 15))) : rand_pc();
      if (r1 && r2 && m_slot(p1) == m_slot(p2) &&
          line_of(p1) != line_of(p2)) p2 = p1;
      fm = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 19) == 0) hold_tok++;
      if ($urandom_range(0, 19) == 0) flush_idle();
      run_group(r1, p1, r2, p2, fm);
      n++;
    end

    // Reset in the middle of a refill abandons it.
    flush_idle();
    req_q.push_back(32'h300);
    reqF1 = 1'b1;
    pcF1  = 32'h300;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (responder.busy && responder.beat >= 1) break;
      n++;
    end
    chk("rst_test_reached_fill", 32'(n < 200), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midfill_rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("midfill_rst_validF1", 32'(validF1), 32'd0);
    reqF1 = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run_group(1, 32'h300, 0, 32'h0, 0);
    run_group(1, 32'h30C, 1, 32'h304, 0);

    @(posedge clk);
    #1;
    fetch_active = 1'b0;
    reqF1 = 1'b0;
    reqF2 = 1'b0;
    repeat (8) @(negedge clk);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    chk("final_mem_req_valid", 32'(mem_req_valid), 32'd0);
    summary_and_finish();
  end

endmodule
